// File: rtl/id_operand_scoreboard.sv
// Decode-stage register file with per-register in-flight write counters.
// Resolves NREAD operands through a priority bypass network and raises the ID stall.

module id_operand_resolve #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int CW    = 2,
    parameter int NFWD  = 3
) (
    input  logic [AW-1:0]         addr,
    input  logic [NFWD-1:0]       fwd_valid,
    input  logic [NFWD*AW-1:0]    fwd_rd,
    input  logic [NFWD*WIDTH-1:0] fwd_data,
    input  logic [NFWD-1:0]       fwd_data_ok,
    input  logic                  wb_valid,
    input  logic [AW-1:0]         wb_rd,
    input  logic [WIDTH-1:0]      wb_data,
    input  logic [WIDTH-1:0]      rf_data,
    input  logic [CW-1:0]         cnt_a,
    output logic [WIDTH-1:0]      data,
    output logic                  ready
);
    always_comb begin
        data  = rf_data;
        ready = (cnt_a == '0);
        if (wb_valid && wb_rd == addr) begin
            data  = wb_data;
            ready = (cnt_a == CW'(1));
        end
        // Walk oldest to youngest so the lowest matching index wins.
        for (int j = NFWD - 1; j >= 0; j--) begin
            if (fwd_valid[j] && fwd_rd[j*AW +: AW] == addr) begin
                data  = fwd_data[j*WIDTH +: WIDTH];
                ready = fwd_data_ok[j];
            end
        end
        if (addr == '0) begin
            data  = '0;
            ready = 1'b1;
        end
    end
endmodule

module id_operand_scoreboard #(
    parameter int WIDTH   = 32,
    parameter int NREGS   = 32,
    parameter int NREAD   = 2,
    parameter int NFWD    = 3,
    parameter int NKILL   = 2,
    parameter int MAXPEND = 3,
    localparam int AW     = $clog2(NREGS),
    localparam int CW     = $clog2(MAXPEND + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic                   issue_we,
    input  logic [AW-1:0]          issue_rd,
    input  logic [NREAD-1:0]       rs_used,
    input  logic [NREAD*AW-1:0]    rs_addr,
    output logic [NREAD*WIDTH-1:0] rs_data,
    output logic [NREAD-1:0]       rs_ready,
    output logic                   stall,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD*AW-1:0]     fwd_rd,
    input  logic [NFWD*WIDTH-1:0]  fwd_data,
    input  logic [NFWD-1:0]        fwd_data_ok,
    input  logic                   wb_valid,
    input  logic [AW-1:0]          wb_rd,
    input  logic [WIDTH-1:0]       wb_data,
    input  logic [NKILL-1:0]       kill_valid,
    input  logic [NKILL*AW-1:0]    kill_rd,
    output logic                   pending_any,
    output logic                   err
);
    logic [WIDTH-1:0]           rf [NREGS];
    logic [NREGS-1:0][CW-1:0]   cnt, cnt_nxt;
    logic                       err_set;
    logic                       issue_fire;
    logic                       sat;

    for (genvar i = 0; i < NREAD; i++) begin : g_port
        logic [AW-1:0] a;
        assign a = rs_addr[i*AW +: AW];
        id_operand_resolve #(.WIDTH(WIDTH), .AW(AW), .CW(CW), .NFWD(NFWD)) u_res (
            .addr        (a),
            .fwd_valid   (fwd_valid),
            .fwd_rd      (fwd_rd),
            .fwd_data    (fwd_data),
            .fwd_data_ok (fwd_data_ok),
            .wb_valid    (wb_valid),
            .wb_rd       (wb_rd),
            .wb_data     (wb_data),
            .rf_data     (rf[a]),
            .cnt_a       (cnt[a]),
            .data        (rs_data[i*WIDTH +: WIDTH]),
            .ready       (rs_ready[i])
        );
    end

    // Saturation check deliberately ignores any same-cycle decrement.
    assign sat        = issue_we && issue_rd != '0 && cnt[issue_rd] == CW'(MAXPEND);
    assign stall      = issue_valid && ((|(rs_used & ~rs_ready)) || sat);
    assign issue_fire = issue_valid && !stall && issue_we;
    assign pending_any = |cnt;

    always_comb begin
        int inc, dec;
        inc     = 0;
        dec     = 0;
        cnt_nxt = cnt;
        err_set = 1'b0;
        cnt_nxt[0] = '0;
        for (int r = 1; r < NREGS; r++) begin
            inc = (issue_fire && issue_rd == AW'(r)) ? 1 : 0;
            dec = (wb_valid && wb_rd == AW'(r)) ? 1 : 0;
            for (int k = 0; k < NKILL; k++)
                if (kill_valid[k] && kill_rd[k*AW +: AW] == AW'(r)) dec = dec + 1;
            if (dec > int'(cnt[r]) + inc) begin
                cnt_nxt[r] = '0;
                err_set    = 1'b1;
            end else begin
                cnt_nxt[r] = CW'(int'(cnt[r]) + inc - dec);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
            for (int r = 0; r < NREGS; r++) rf[r] <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (err_set) err <= 1'b1;
            if (wb_valid && wb_rd != '0) rf[wb_rd] <= wb_data;
        end
    end
endmodule

// File: tb/tb_id_operand_scoreboard.sv
// Randomised plus directed check of id_operand_scoreboard against an array-based model.

module tb_id_operand_scoreboard;
    localparam int WIDTH = 32, NREGS = 32, NREAD = 2, NFWD = 3, NKILL = 2, MAXPEND = 3;
    localparam int AW = 5, CW = 2;

    logic clk = 1'b0, rst = 1'b1;
    logic issue_valid, issue_we;
    logic [AW-1:0] issue_rd;
    logic [NREAD-1:0] rs_used;
    logic [NREAD*AW-1:0] rs_addr;
    logic [NREAD*WIDTH-1:0] rs_data;
    logic [NREAD-1:0] rs_ready;
    logic stall;
    logic [NFWD-1:0] fwd_valid, fwd_data_ok;
    logic [NFWD*AW-1:0] fwd_rd;
    logic [NFWD*WIDTH-1:0] fwd_data;
    logic wb_valid;
    logic [AW-1:0] wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic [NKILL-1:0] kill_valid;
    logic [NKILL*AW-1:0] kill_rd;
    logic pending_any, err;

    id_operand_scoreboard #(.WIDTH(WIDTH), .NREGS(NREGS), .NREAD(NREAD), .NFWD(NFWD),
                            .NKILL(NKILL), .MAXPEND(MAXPEND)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_rd(issue_rd), .rs_used(rs_used), .rs_addr(rs_addr), .rs_data(rs_data),
        .rs_ready(rs_ready), .stall(stall), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .fwd_data_ok(fwd_data_ok), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .kill_valid(kill_valid), .kill_rd(kill_rd),
        .pending_any(pending_any), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int mcnt [NREGS];
    logic [WIDTH-1:0] mrf [NREGS];
    logic merr;
    logic [WIDTH-1:0] exp_data [NREAD];
    logic exp_rdy [NREAD];
    logic exp_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin mcnt[r] = 0; mrf[r] = '0; end
        merr = 1'b0;
    endtask

    // Spec-level operand resolution and stall from current inputs and model state.
    task automatic model_eval();
        logic any_nr;
        any_nr = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            int a;
            bit found;
            a = int'(rs_addr[i*AW +: AW]);
            found = 0;
            if (a == 0) begin exp_data[i] = '0; exp_rdy[i] = 1'b1; found = 1; end
            for (int j = 0; j < NFWD; j++)
                if (!found && fwd_valid[j] && int'(fwd_rd[j*AW +: AW]) == a) begin
                    exp_data[i] = fwd_data[j*WIDTH +: WIDTH];
                    exp_rdy[i] = fwd_data_ok[j];
                    found = 1;
                end
            if (!found && wb_valid && int'(wb_rd) == a) begin
                exp_data[i] = wb_data; exp_rdy[i] = (mcnt[a] == 1); found = 1;
            end
            if (!found) begin exp_data[i] = mrf[a]; exp_rdy[i] = (mcnt[a] == 0); end
            if (rs_used[i] && !exp_rdy[i]) any_nr = 1'b1;
        end
        exp_stall = issue_valid && (any_nr ||
                    (issue_we && issue_rd != 0 && mcnt[issue_rd] == MAXPEND));
    endtask

    task automatic model_update();
        for (int r = 1; r < NREGS; r++) begin
            int inc, dec;
            inc = (issue_valid && !exp_stall && issue_we && int'(issue_rd) == r) ? 1 : 0;
            dec = (wb_valid && int'(wb_rd) == r) ? 1 : 0;
            for (int k = 0; k < NKILL; k++)
                if (kill_valid[k] && int'(kill_rd[k*AW +: AW]) == r) dec++;
            if (dec > mcnt[r] + inc) begin mcnt[r] = 0; merr = 1'b1; end
            else mcnt[r] = mcnt[r] + inc - dec;
        end
        if (wb_valid && wb_rd != 0) mrf[wb_rd] = wb_data;
    endtask

    function automatic logic model_pending();
        for (int r = 0; r < NREGS; r++) if (mcnt[r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Compare all outputs against the model at the falling edge.
    task automatic mid();
        @(negedge clk);
        model_eval();
        for (int i = 0; i < NREAD; i++) begin
            chk($sformatf("rs_data%0d", i), 64'(rs_data[i*WIDTH +: WIDTH]), 64'(exp_data[i]));
            chk($sformatf("rs_ready%0d", i), 64'(rs_ready[i]), 64'(exp_rdy[i]));
        end
        chk("stall", 64'(stall), 64'(exp_stall));
        chk("pending_any", 64'(pending_any), 64'(model_pending()));
        chk("err", 64'(err), 64'(merr));
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_we = 0; issue_rd = '0; rs_used = '0; rs_addr = '0;
        fwd_valid = '0; fwd_rd = '0; fwd_data = '0; fwd_data_ok = '0;
        wb_valid = 0; wb_rd = '0; wb_data = '0; kill_valid = '0; kill_rd = '0;
    endtask

    task automatic issue_w(input int rd);
        idle(); issue_valid = 1; issue_we = 1; issue_rd = AW'(rd);
    endtask

    task automatic read0(input int a);
        issue_valid = 1; rs_used[0] = 1'b1; rs_addr[0 +: AW] = AW'(a);
    endtask

    task automatic randomize_inputs();
        idle();
        issue_valid = ($urandom_range(0, 3) != 0);
        issue_we = $urandom_range(0, 1);
        issue_rd = AW'($urandom_range(0, 7));
        for (int i = 0; i < NREAD; i++) begin
            rs_used[i] = $urandom_range(0, 1);
            rs_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
        end
        for (int j = 0; j < NFWD; j++) begin
            fwd_valid[j] = ($urandom_range(0, 2) == 0);
            fwd_rd[j*AW +: AW] = AW'($urandom_range(0, 7));
            fwd_data[j*WIDTH +: WIDTH] = $urandom;
            fwd_data_ok[j] = ($urandom_range(0, 3) != 0);
        end
        wb_valid = ($urandom_range(0, 2) == 0);
        wb_rd = AW'($urandom_range(0, 7));
        wb_data = $urandom;
        for (int k = 0; k < NKILL; k++) begin
            kill_valid[k] = ($urandom_range(0, 15) == 0);
            kill_rd[k*AW +: AW] = AW'($urandom_range(1, 7));
        end
    endtask

    initial begin
        idle();
        model_reset();
        #12 rst = 1'b0;

        // Reset state with an unforwarded read
        read0(4);
        mid();
        chk("rst_pending", 64'(pending_any), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_ready", 64'(rs_ready[0]), 64'd1);
        adv();

        // x5 in flight, then read without and with an EX bypass
        issue_w(5); mid(); adv();
        idle(); read0(5); mid();
        chk("x5_ready", 64'(rs_ready[0]), 64'd0);
        chk("x5_stall", 64'(stall), 64'd1);
        adv();
        fwd_valid[0] = 1; fwd_rd[0 +: AW] = 5; fwd_data[0 +: WIDTH] = 32'hDEADBEEF; fwd_data_ok[0] = 1;
        mid();
        chk("fwd_data", 64'(rs_data[0 +: WIDTH]), 64'hDEADBEEF);
        chk("fwd_stall", 64'(stall), 64'd0);
        adv();

        // EX beats MEM; a not-ok EX hides an ok MEM
        idle(); read0(5);
        fwd_valid = 3'b011; fwd_rd[0 +: AW] = 5; fwd_rd[AW +: AW] = 5;
        fwd_data[0 +: WIDTH] = 32'h11; fwd_data[WIDTH +: WIDTH] = 32'h22; fwd_data_ok = 3'b011;
        mid();
        chk("prio_data", 64'(rs_data[0 +: WIDTH]), 64'h11);
        adv();
        fwd_data_ok[0] = 0;
        mid();
        chk("load_use_stall", 64'(stall), 64'd1);
        adv();

        // Write-through on commit, then register-file read
        issue_w(7); mid(); adv();
        idle(); issue_valid = 1; rs_used[1] = 1; rs_addr[AW +: AW] = 7;
        wb_valid = 1; wb_rd = 7; wb_data = 32'hA5A5A5A5;
        mid();
        chk("wt_ready", 64'(rs_ready[1]), 64'd1);
        chk("wt_data", 64'(rs_data[WIDTH +: WIDTH]), 64'hA5A5A5A5);
        adv();
        wb_valid = 0; mid();
        chk("rf_data", 64'(rs_data[WIDTH +: WIDTH]), 64'hA5A5A5A5);
        chk("rf_ready", 64'(rs_ready[1]), 64'd1);
        adv();

        // Saturation at MAXPEND on x3
        for (int n = 0; n < 3; n++) begin issue_w(3); mid(); adv(); end
        issue_w(3); mid();
        chk("sat_stall", 64'(stall), 64'd1);
        adv();
        wb_valid = 1; wb_rd = 3; mid();
        chk("sat_stall_wb", 64'(stall), 64'd1);
        adv();
        wb_valid = 0; mid();
        chk("sat_retry", 64'(stall), 64'd0);
        adv();
        chk("model_cnt3", 64'(mcnt[3]), 64'd3);

        // Double kill underflow on x9
        issue_w(9); mid(); adv();
        idle(); kill_valid = 2'b11; kill_rd = {5'd9, 5'd9}; mid(); adv();
        idle(); mid();
        chk("err_set", 64'(err), 64'd1);
        chk("pend_after_kill", 64'(pending_any), 64'd1);
        adv();
        for (int n = 0; n < 4; n++) begin
            idle(); wb_valid = 1; wb_rd = (n < 3) ? 5'd3 : 5'd5; wb_data = 32'(n); mid(); adv();
        end
        idle(); mid();
        chk("drained", 64'(pending_any), 64'd0);
        chk("err_sticky", 64'(err), 64'd1);
        adv();

        // x0 ignores bypass and writes
        read0(0); fwd_valid[0] = 1; fwd_rd[0 +: AW] = 0; fwd_data[0 +: WIDTH] = 32'hFFFFFFFF;
        fwd_data_ok[0] = 0;
        wb_valid = 1; wb_rd = 0; wb_data = 32'h1234;
        mid();
        chk("x0_data", 64'(rs_data[0 +: WIDTH]), 64'd0);
        chk("x0_ready", 64'(rs_ready[0]), 64'd1);
        adv();
        idle(); read0(0); mid();
        chk("x0_after_wb", 64'(rs_data[0 +: WIDTH]), 64'd0);
        adv();

        // Randomised traffic, with a mid-run reset
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst = 1'b1; #1;
                chk("async_rst_pending", 64'(pending_any), 64'd0);
                chk("async_rst_err", 64'(err), 64'd0);
                model_reset();
                @(posedge clk); #1 rst = 1'b0;
            end
            randomize_inputs();
            mid();
            adv();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_operand_scoreboard.md
# id_operand_scoreboard

Parametrised successor to the decode-stage register file and operand-forwarding mux. It holds the architectural register file and keeps a per-register scoreboard of in-flight writes. It resolves NREAD source operands per cycle through a priority-ordered bypass network and raises a decode stall when any used operand is not yet available. It sits in ID, between the IF/ID and ID/EX pipeline registers.

## Interface
Parameters:
- WIDTH, 32, data width
- NREGS, 32, architectural registers; AW = $clog2(NREGS)
- NREAD, 2, source-operand read ports
- NFWD, 3, bypass sources; index 0 is youngest (EX), then MEM, then later stages
- NKILL, 2, squash-notification ports
- MAXPEND, 3, maximum in-flight writes per register; counter width CW = $clog2(MAXPEND+1)

Ports (reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- issue_valid  in  1  instruction present in ID this cycle
- issue_we  in  1  instruction writes issue_rd
- issue_rd  in  AW  destination register
- rs_used  in  NREAD  operand i is consumed
- rs_addr  in  NREAD*AW  operand addresses, port i at [i*AW +: AW]
- rs_data  out  NREAD*WIDTH  resolved operand values
- rs_ready  out  NREAD  operand i is valid this cycle
- stall  out  1  hold ID and insert a bubble
- fwd_valid  in  NFWD  bypass source carries a register write
- fwd_rd  in  NFWD*AW  bypass destination
- fwd_data  in  NFWD*WIDTH  bypass value
- fwd_data_ok  in  NFWD  value is final (0 for a load still in EX)
- wb_valid  in  1  commit write this cycle
- wb_rd  in  AW  commit destination
- wb_data  in  WIDTH  commit value
- kill_valid  in  NKILL  squashed in-flight writer notification
- kill_rd  in  NKILL*AW  squashed writer's destination
- pending_any  out  1  some register has count > 0
- err  out  1  sticky underflow error

## Operation
Storage:
- The register file is NREGS x WIDTH. On wb_valid with wb_rd != 0 the register is written at the clk edge.
- Register x0 reads 0, is always ready, is never counted, and ignores writes.

Per-register pending count cnt[r] (CW bits). The next value is cnt + inc − dec, computed in one summed update:
- inc = issue_valid && !stall && issue_we && issue_rd == r && r != 0
- dec = (wb_valid && wb_rd == r) + the number of kill ports with kill_valid && kill_rd == r
- If dec exceeds cnt + inc, cnt goes to 0 and err sets. err clears only on rst.

Operand resolution for each port i. Let a = rs_addr[i]; the first matching rule applies:
1. a == 0: data 0, ready 1.
2. The lowest fwd index j with fwd_valid[j] && fwd_rd[j] == a: data fwd_data[j], ready fwd_data_ok[j].
3. wb_valid && wb_rd == a: data wb_data (write-through), ready = (cnt[a] == 1).
4. Otherwise: data from the register file, ready = (cnt[a] == 0).

Stall:
- stall = issue_valid && (any i: rs_used[i] && !rs_ready[i] || issue_we && issue_rd != 0 && cnt[issue_rd] == MAXPEND).
- The saturation test ignores a same-cycle decrement; this is a conservative, structural stall.
- While stall is high, no increment occurs. A stalled instruction re-presents on the next cycle.

Other outputs:
- pending_any = OR of all cnt != 0. It is used for fence and drain.

## Timing
- Resolution is combinational and valid in the same cycle as the inputs (rs_data, rs_ready, stall).
- Register-file writes and counter updates take effect at the rising clk edge. A read in the cycle after a commit sees the new value from the register file.
- Reset, asynchronous: all registers 0, all cnt 0, err 0. Outputs after reset: pending_any 0; stall 0 unless issue_valid with a used operand forwarded not-ok; rs_ready 1 for unforwarded reads.
- Reset mid-operation discards all pending state immediately.
- Simultaneous issue and commit to the same rd: net count change 0.
- Issue of a register that is also read by the same instruction (rd == rs): the operand is resolved against the pre-issue count.
- Multiple kills of the same register in one cycle: each kill decrements by 1.

## Test plan
- Reset, then issue_we rd=5 (cnt[5]=1) and the next instruction reads x5 with no fwd match -> rs_ready=0, stall=1. Then fwd_valid[0] with rd=5, data 0xDEADBEEF, ok=1 -> rs_data=0xDEADBEEF, stall=0.
- x5 is forwarded from both EX (0x11) and MEM (0x22) -> rs_data=0x11. Set EX fwd_data_ok=0 -> stall=1 (load-use), even though MEM data is ok.
- cnt[7]=1, wb_valid rd=7 data 0xA5A5A5A5, same-cycle read of x7 -> ready=1, data 0xA5A5A5A5. Next cycle cnt=0 and the register-file read returns the same value.
- Issue three writes to x3 (MAXPEND=3), then a fourth issue to x3 -> stall=1 and cnt stays 3. One wb to x3 -> the retried issue proceeds next cycle.
- cnt[9]=1, then two kills of rd=9 in one cycle -> cnt=0, err=1 and err stays 1 until rst. pending_any reflects the remaining counts.
- Read x0 while fwd_valid[0] has rd=0, data 0xFFFFFFFF -> rs_data=0, ready=1. wb rd=0 leaves x0 at 0.
